smac_ctrl: RTL and testbench



---
 rtl/smac_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_smac_ctrl.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/smac_ctrl.sv
// smac_ctrl -- sequencer for the serial-MAC array.
//
// Accepts one job (cfg_nvec activation vectors), then for every
// (vector, weight bit-plane) pair runs one pass:
//   LOAD  : take one activation word + weight bit-plane from upstream
//   SHIFT : Pa cycles shifting the activation out MSB-first
//   TAIL  : accumulate the last activation bit
//   BR    : latch the bit-plane result (sign plane uses MSB_w/we_neg)
//   AC2   : fold into the second-level accumulator, advance counters
// After nvec*Pw passes it holds DONE until the result is taken.
//
// Handshakes: a transfer happens on a rising clk edge where valid and
// ready are both high. in_ready is high only in LOAD. out_valid is
// high only in DONE and stays high until out_ready is seen.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, cfg_nvec   job request (sampled in IDLE only), vector count
//   in_valid/in_ready upstream beat handshake
//   out_valid/out_ready result handshake
//   busy              high in every state except IDLE
//   vec_idx, wbit_idx current vector / bit-plane (0 = MSB plane)
//   we_ar_mod .. cl_en_ac2  array control strobes
//   dbg_state         current FSM state encoding (debug)
module smac_ctrl #(
    parameter int Pa = 8,
    parameter int Pw = 4,
    parameter int NW = 8,
    localparam int WBW = (Pw > 1) ? $clog2(Pw) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [NW-1:0]  cfg_nvec,
    input  logic           in_valid,
    output logic           in_ready,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           busy,
    output logic [NW-1:0]  vec_idx,
    output logic [WBW-1:0] wbit_idx,
    output logic           we_ar_mod,
    output logic           se_ar_mod,
    output logic           we_a,
    output logic           we_w,
    output logic           we_br,
    output logic           we_neg,
    output logic           MSB_a,
    output logic           MSB_w,
    output logic           we_ac1,
    output logic           we_ac2,
    output logic           cl_en_ac1,
    output logic           cl_en_ac2,
    output logic [2:0]     dbg_state
);

    localparam int BCW = (Pa > 1) ? $clog2(Pa) : 1;
    localparam logic [BCW-1:0] BCNT_LAST = BCW'(Pa - 1);
    localparam logic [WBW-1:0] WBIT_LAST = WBW'(Pw - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SHIFT = 3'd2,
        TAIL  = 3'd3,
        BR    = 3'd4,
        AC2   = 3'd5,
        DONE  = 3'd6
    } state_t;

    state_t         state_q, state_d;
    logic [BCW-1:0] bcnt_q, bcnt_d;
    logic [NW-1:0]  nvec_q, nvec_d;
    logic [NW-1:0]  vec_d;
    logic [WBW-1:0] wbit_d;
    logic           last_pass;

    // Next values of the registered outputs.
    logic in_ready_d, busy_d, out_valid_d;
    logic se_ar_mod_d, we_a_d, we_br_d, we_neg_d, msb_a_d, msb_w_d;
    logic we_ac1_d, we_ac2_d, cl_en_ac1_d, cl_en_ac2_d;

    assign last_pass = (vec_idx == nvec_q - NW'(1)) && (wbit_idx == WBIT_LAST);

    // The load strobes mark the accepted beat itself, so they qualify the
    // registered LOAD window with the live in_valid.
    assign we_ar_mod = in_ready & in_valid;
    assign we_w      = in_ready & in_valid;
    assign dbg_state = state_q;

    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        nvec_d  = nvec_q;
        vec_d   = vec_idx;
        wbit_d  = wbit_idx;

        case (state_q)
            IDLE: begin
                if (start && (cfg_nvec != '0)) begin
                    nvec_d  = cfg_nvec;
                    vec_d   = '0;
                    wbit_d  = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    bcnt_d  = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (bcnt_q == BCNT_LAST) begin
                    state_d = TAIL;
                end else begin
                    bcnt_d = bcnt_q + BCW'(1);
                end
            end
            TAIL: state_d = BR;
            BR:   state_d = AC2;
            AC2: begin
                if (wbit_idx == WBIT_LAST) begin
                    wbit_d = '0;
                    vec_d  = vec_idx + NW'(1);
                end else begin
                    wbit_d = wbit_idx + WBW'(1);
                end
                state_d = last_pass ? DONE : LOAD;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so that, once registered,
        // they line up exactly with the state they belong to.
        in_ready_d  = (state_d == LOAD);
        busy_d      = (state_d != IDLE);
        out_valid_d = (state_d == DONE);
        se_ar_mod_d = (state_d == SHIFT);
        we_a_d      = (state_d == SHIFT);
        // The activation MSB reaches the input register one cycle into
        // SHIFT, so accumulation starts at bcnt=1 and runs into TAIL.
        we_ac1_d    = ((state_d == SHIFT) && (bcnt_d != '0)) || (state_d == TAIL);
        msb_a_d     = (state_d == SHIFT) && (bcnt_d == BCW'(1));
        cl_en_ac1_d = (state_d == SHIFT) && (bcnt_d == BCW'(1));
        we_br_d     = (state_d == BR);
        // Plane 0 is the two's-complement sign plane.
        msb_w_d     = (state_d == BR) && (wbit_d == '0);
        we_neg_d    = (state_d == BR) && (wbit_d == '0);
        we_ac2_d    = (state_d == AC2);
        cl_en_ac2_d = (state_d == AC2) && (vec_d == '0) && (wbit_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bcnt_q    <= '0;
            nvec_q    <= '0;
            vec_idx   <= '0;
            wbit_idx  <= '0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            se_ar_mod <= 1'b0;
            we_a      <= 1'b0;
            we_br     <= 1'b0;
            we_neg    <= 1'b0;
            MSB_a     <= 1'b0;
            MSB_w     <= 1'b0;
            we_ac1    <= 1'b0;
            we_ac2    <= 1'b0;
            cl_en_ac1 <= 1'b0;
            cl_en_ac2 <= 1'b0;
        end else begin
            state_q   <= state_d;
            bcnt_q    <= bcnt_d;
            nvec_q    <= nvec_d;
            vec_idx   <= vec_d;
            wbit_idx  <= wbit_d;
            in_ready  <= in_ready_d;
            busy      <= busy_d;
            out_valid <= out_valid_d;
            se_ar_mod <= se_ar_mod_d;
            we_a      <= we_a_d;
            we_br     <= we_br_d;
            we_neg    <= we_neg_d;
            MSB_a     <= msb_a_d;
            MSB_w     <= msb_w_d;
            we_ac1    <= we_ac1_d;
            we_ac2    <= we_ac2_d;
            cl_en_ac1 <= cl_en_ac1_d;
            cl_en_ac2 <= cl_en_ac2_d;
        end
    end

endmodule

// File: tb/tb_smac_ctrl.sv
// Self-checking bench for smac_ctrl: the job driver pushes the expected
// passes and job completions into queues; monitors pop and compare them
// against what the sequencer presents.
module tb_smac_ctrl;

    localparam int PA = 8;
    localparam int PW = 4;
    localparam int NW = 8;
    localparam int PASS_LEN = PA + 4;

    // Control-word bit positions inside obs[24:10].
    localparam int B_IN_READY  = 14;
    localparam int B_BUSY      = 13;
    localparam int B_OUT_VALID = 12;
    localparam int B_AR_MOD    = 11;
    localparam int B_SE        = 10;
    localparam int B_WE_A      = 9;
    localparam int B_WE_W      = 8;
    localparam int B_BR        = 7;
    localparam int B_NEG       = 6;
    localparam int B_MSB_A     = 5;
    localparam int B_MSB_W     = 4;
    localparam int B_AC1       = 3;
    localparam int B_AC2       = 2;
    localparam int B_CL1       = 1;
    localparam int B_CL2       = 0;

    typedef struct { int vec; int wbit; } pass_t;
    typedef struct { int start_cyc; int nvec; } job_t;

    logic          clk = 1'b0;
    logic          rst, start, in_valid, out_ready;
    logic [NW-1:0] cfg_nvec;
    logic          in_ready, out_valid, busy;
    logic [NW-1:0] vec_idx;
    logic [1:0]    wbit_idx;
    logic          we_ar_mod, se_ar_mod, we_a, we_w, we_br, we_neg;
    logic          MSB_a, MSB_w, we_ac1, we_ac2, cl_en_ac1, cl_en_ac2;
    logic [2:0]    dbg_state;
    logic [24:0]   obs;

    int    n_checks = 0;
    int    n_fail = 0;
    int    cyc = 0;
    int    jobs_issued = 0;
    int    jobs_done = 0;
    int    stall_cnt = 0;
    int    last_lat = 0;
    bit    mon_en = 1'b0;
    bit    iv_rand = 1'b0;
    bit    or_rand = 1'b0;
    int    cnt_ar = 0, cnt_w = 0, cnt_br = 0, cnt_ac2 = 0;
    int    cnt_msb_a = 0, cnt_msb_w = 0, cnt_neg = 0, cnt_cl2 = 0;

    pass_t pass_q[$];
    job_t  job_q[$];

    smac_ctrl #(.Pa(PA), .Pw(PW), .NW(NW)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_nvec(cfg_nvec),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .vec_idx(vec_idx), .wbit_idx(wbit_idx),
        .we_ar_mod(we_ar_mod), .se_ar_mod(se_ar_mod), .we_a(we_a), .we_w(we_w),
        .we_br(we_br), .we_neg(we_neg), .MSB_a(MSB_a), .MSB_w(MSB_w),
        .we_ac1(we_ac1), .we_ac2(we_ac2), .cl_en_ac1(cl_en_ac1), .cl_en_ac2(cl_en_ac2),
        .dbg_state(dbg_state)
    );

    assign obs = {in_ready, busy, out_valid, we_ar_mod, se_ar_mod, we_a, we_w,
                  we_br, we_neg, MSB_a, MSB_w, we_ac1, we_ac2, cl_en_ac1, cl_en_ac2,
                  vec_idx, wbit_idx};

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (we_ar_mod) cnt_ar    <= cnt_ar + 1;
        if (we_w)      cnt_w     <= cnt_w + 1;
        if (we_br)     cnt_br    <= cnt_br + 1;
        if (we_ac2)    cnt_ac2   <= cnt_ac2 + 1;
        if (MSB_a)     cnt_msb_a <= cnt_msb_a + 1;
        if (MSB_w)     cnt_msb_w <= cnt_msb_w + 1;
        if (we_neg)    cnt_neg   <= cnt_neg + 1;
        if (cl_en_ac2) cnt_cl2   <= cnt_cl2 + 1;
    end

    // Background random handshake drivers, offset from the directed drivers.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (iv_rand) in_valid = ($urandom_range(0, 3) != 0);
            if (or_rand) out_ready = ($urandom_range(0, 2) == 0);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference schedule of one pass. k = -1 is the LOAD cycle that takes
    // the beat, 0..PA-1 the shift cycles, then TAIL, BR and AC2.
    function automatic logic [24:0] exp_pass(input int k, input pass_t p);
        logic [14:0] c;
        c = '0;
        c[B_BUSY] = 1'b1;
        if (k < 0) begin
            c[B_IN_READY] = 1'b1;
            c[B_AR_MOD]   = 1'b1;
            c[B_WE_W]     = 1'b1;
        end else if (k < PA) begin
            c[B_SE]    = 1'b1;
            c[B_WE_A]  = 1'b1;
            c[B_AC1]   = (k >= 1);
            c[B_MSB_A] = (k == 1);
            c[B_CL1]   = (k == 1);
        end else if (k == PA) begin
            c[B_AC1] = 1'b1;
        end else if (k == PA + 1) begin
            c[B_BR]    = 1'b1;
            c[B_MSB_W] = (p.wbit == 0);
            c[B_NEG]   = (p.wbit == 0);
        end else begin
            c[B_AC2] = 1'b1;
            c[B_CL2] = (p.vec == 0) && (p.wbit == 0);
        end
        return {c, 8'(p.vec), 2'(p.wbit)};
    endfunction

    function automatic logic [24:0] exp_stall(input pass_t p);
        logic [14:0] c;
        c = '0;
        c[B_BUSY]     = 1'b1;
        c[B_IN_READY] = 1'b1;
        return {c, 8'(p.vec), 2'(p.wbit)};
    endfunction

    // ---------------- pass monitor ----------------
    initial begin
        pass_t p;
        forever begin
            @(negedge clk);
            if (!mon_en || rst) continue;
            if (in_ready) begin
                if (pass_q.size() == 0) begin
                    check("unexpected_load", in_ready, 1'b0);
                    continue;
                end
                p = pass_q[0];
                if (!in_valid) begin
                    stall_cnt++;
                    check("stall_cycle", obs, exp_stall(p));
                end else begin
                    void'(pass_q.pop_front());
                    check("load_accept", obs, exp_pass(-1, p));
                    for (int k = 0; k < PA + 3; k++) begin
                        @(negedge clk);
                        if (!mon_en) break;
                        check($sformatf("pass_v%0d_w%0d_k%0d", p.vec, p.wbit, k), obs, exp_pass(k, p));
                    end
                end
            end else begin
                check("quiet_strobes", obs[21:10], 12'h000);
            end
        end
    end

    // ---------------- completion monitor ----------------
    initial begin
        bit   prev_ov, prev_or;
        int   stall_base, stalls, exp_cyc;
        job_t j;
        prev_ov = 1'b0;
        prev_or = 1'b0;
        stall_base = 0;
        forever begin
            @(negedge clk);
            if (!mon_en || rst) begin
                prev_ov = 1'b0;
                stall_base = stall_cnt;
                continue;
            end
            if (prev_ov && prev_or) begin
                check("release_out_valid", out_valid, 1'b0);
                check("release_idle", {busy, dbg_state}, 4'h0);
                jobs_done++;
            end else if (prev_ov) begin
                check("hold_out_valid_busy", {out_valid, busy}, 2'b11);
            end else if (out_valid) begin
                if (job_q.size() == 0) begin
                    check("unexpected_done", out_valid, 1'b0);
                end else begin
                    j = job_q.pop_front();
                    stalls = stall_cnt - stall_base;
                    stall_base = stall_cnt;
                    exp_cyc = j.start_cyc + 1 + j.nvec * PW * PASS_LEN + stalls;
                    last_lat = cyc - j.start_cyc;
                    check("done_latency", cyc, exp_cyc);
                    check("done_passes_left", pass_q.size(), 0);
                end
            end
            prev_ov = out_valid;
            prev_or = out_ready;
        end
    end

    // ---------------- driver tasks ----------------
    // Caller is positioned just after a rising edge.
    task automatic apply_reset();
        mon_en = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {obs, dbg_state}, 28'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        start = 1'b0;
        pass_q.delete();
        job_q.delete();
        jobs_issued = jobs_done;
        mon_en = 1'b1;
    endtask

    task automatic start_job(input int nvec);
        job_t j;
        @(posedge clk);
        #1;
        start = 1'b1;
        cfg_nvec = NW'(nvec);
        if (nvec != 0) begin
            j.start_cyc = cyc;
            j.nvec = nvec;
            job_q.push_back(j);
            for (int v = 0; v < nvec; v++)
                for (int w = 0; w < PW; w++)
                    pass_q.push_back('{vec: v, wbit: w});
            jobs_issued++;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        cfg_nvec = NW'($urandom_range(0, 255));
    endtask

    task automatic spurious_start(input int nvec);
        @(posedge clk);
        #1;
        start = 1'b1;
        cfg_nvec = NW'(nvec);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int n;
        n = 0;
        while (jobs_done != jobs_issued && n < limit) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (jobs_done != jobs_issued) begin
            check("job_timeout", jobs_done, jobs_issued);
            apply_reset();
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int b_ar, b_w, b_br, b_ac2, b_msba, b_msbw, b_neg, b_cl2;
        rst = 1'b1;
        start = 1'b0;
        cfg_nvec = '0;
        in_valid = 1'b0;
        out_ready = 1'b0;

        @(posedge clk);
        #1;
        apply_reset();

        // Single-vector job, no stalls, no back-pressure.
        in_valid = 1'b1;
        out_ready = 1'b1;
        b_ar = cnt_ar; b_w = cnt_w; b_br = cnt_br; b_ac2 = cnt_ac2;
        b_msba = cnt_msb_a; b_msbw = cnt_msb_w; b_neg = cnt_neg; b_cl2 = cnt_cl2;
        start_job(1);
        wait_done(200);
        check("single_latency", last_lat, 49);
        check("single_we_ar_mod", cnt_ar - b_ar, 4);
        check("single_we_w", cnt_w - b_w, 4);
        check("single_we_br", cnt_br - b_br, 4);
        check("single_we_ac2", cnt_ac2 - b_ac2, 4);
        check("single_msb_a", cnt_msb_a - b_msba, 4);
        check("single_msb_w", cnt_msb_w - b_msbw, 1);
        check("single_we_neg", cnt_neg - b_neg, 1);
        check("single_cl_en_ac2", cnt_cl2 - b_cl2, 1);

        // Upstream stall: 5 dead cycles in the third LOAD of a 2-vector job.
        start_job(2);
        repeat (24) @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        in_valid = 1'b1;
        wait_done(300);
        check("stall_latency", last_lat, 1 + 8 * PASS_LEN + 5);

        // Back-pressure in DONE, with starts during the job and in DONE.
        out_ready = 1'b0;
        start_job(1);
        repeat (5) @(posedge clk);
        spurious_start(3);
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        check("bp_reached_done", out_valid, 1'b1);
        spurious_start(2);
        repeat (8) @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_done(50);
        repeat (2) @(negedge clk);
        check("bp_start_in_done_ignored", {busy, in_ready}, 2'b00);

        // Zero-length job request.
        start_job(0);
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            check("zero_len_idle", {busy, in_ready, obs[21:10]}, 14'h0);
        end

        // Randomised jobs with random handshakes and stray starts.
        iv_rand = 1'b1;
        or_rand = 1'b1;
        for (int t = 0; t < 6; t++) begin
            repeat ($urandom_range(0, 4)) @(posedge clk);
            #1;
            start_job($urandom_range(1, 3));
            repeat ($urandom_range(3, 10)) @(posedge clk);
            spurious_start($urandom_range(0, 3));
            wait_done(2000);
        end
        iv_rand = 1'b0;
        or_rand = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        wait_done(200);

        // Reset during SHIFT of pass 2, then a fresh full job.
        start_job(1);
        repeat (15) @(posedge clk);
        #1;
        check("pre_reset_in_shift", {se_ar_mod, wbit_idx}, 3'b1_01);
        apply_reset();
        b_ac2 = cnt_ac2;
        b_cl2 = cnt_cl2;
        start_job(1);
        wait_done(200);
        check("after_reset_latency", last_lat, 49);
        check("after_reset_we_ac2", cnt_ac2 - b_ac2, 4);
        check("after_reset_cl_en_ac2", cnt_cl2 - b_cl2, 1);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
